// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// Build option: define SAR_EARLY_EXIT_EN to let the search stop as soon as the
// comparator reports equality (see sar_search_controller).
package sar_search_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } sar_state_t;

    // Indexed by {a_greater, equal, b_greater}: a bit is 1 where exactly one
    // flag is high (patterns 001, 010, 100), i.e. the comparator output is legal.
    localparam logic [7:0] FLAG_LEGAL_MASK = 8'b0001_0110;

    function automatic logic flags_legal(input logic a_greater,
                                         input logic equal,
                                         input logic b_greater);
        return FLAG_LEGAL_MASK[{a_greater, equal, b_greater}];
    endfunction

endpackage

// File: rtl/sar_probe_step.sv
// One successive-approximation step: decide the bit under test from the
// comparator result, then raise the next lower bit as the following trial.
module sar_probe_step #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] probe,
    input  logic [IDX_W-1:0] bit_idx,
    input  logic             b_greater,
    output logic [WIDTH-1:0] decided,
    output logic [WIDTH-1:0] next_probe
);

    // Clear the trial bit when the probe overshot a; then set the next bit down.
    always_comb begin
        decided = probe;
        if (b_greater) begin
            decided[bit_idx] = 1'b0;
        end
        next_probe = decided;
        if (bit_idx != '0) begin
            next_probe[bit_idx - IDX_W'(1)] = 1'b1;
        end
    end

endmodule

// File: rtl/sar_search_controller.sv
// MSB-first successive-approximation controller driving the `b` operand of a
// combinational magnitude comparator to recover the value on its `a` operand.
// Build option: SAR_EARLY_EXIT_EN ends the search on a legal `equal` flag.
//
// Handshake: `start` is a request sampled only in IDLE (ignored while busy or
// in DONE). `busy` is high for every COMPARE cycle. `done` pulses for exactly
// one cycle when the search ends; `result` is valid from that cycle and held
// until the next accepted start. `flag_error` is sticky over a search.
module sar_search_controller
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a_greater,
    input  logic             equal,
    input  logic             b_greater,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_error,
    output sar_state_t       dbg_state
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t       state, state_nxt;
    logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
    logic [WIDTH-1:0] probe_nxt, result_nxt;
    logic             busy_nxt, done_nxt, flag_error_nxt;
    logic             flags_ok;
    logic             step_b_greater;
    logic [WIDTH-1:0] decided, next_probe;

    // An illegal flag pattern is treated as "keep the bit".
    assign flags_ok       = flags_legal(a_greater, equal, b_greater);
    assign step_b_greater = b_greater & flags_ok;
    assign dbg_state      = state;

    sar_probe_step #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_step (
        .probe      (probe),
        .bit_idx    (bit_idx),
        .b_greater  (step_b_greater),
        .decided    (decided),
        .next_probe (next_probe)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt      = state;
        bit_idx_nxt    = bit_idx;
        probe_nxt      = probe;
        result_nxt     = result;
        flag_error_nxt = flag_error;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    probe_nxt      = MSB_ONE;
                    bit_idx_nxt    = TOP_IDX;
                    flag_error_nxt = 1'b0;
                    busy_nxt       = 1'b1;
                    state_nxt      = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!flags_ok) begin
                    flag_error_nxt = 1'b1;
                end
`ifdef SAR_EARLY_EXIT_EN
                if (flags_ok && equal) begin
                    result_nxt = probe;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_DONE;
                end else
`endif
                if (bit_idx == '0) begin
                    probe_nxt  = decided;
                    result_nxt = decided;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_DONE;
                end else begin
                    probe_nxt   = next_probe;
                    bit_idx_nxt = bit_idx - IDX_W'(1);
                    busy_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset abandons any search in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx    <= '0;
            probe      <= '0;
            result     <= '0;
            flag_error <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bit_idx    <= bit_idx_nxt;
            probe      <= probe_nxt;
            result     <= result_nxt;
            flag_error <= flag_error_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed + randomized bench for sar_search_controller (WIDTH=4) with a
// behavioural comparator on a hidden operand.
module tb_sar_search_controller;
    import sar_search_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         a_greater, equal, b_greater;
    logic [W-1:0] probe;
    logic         busy, done;
    logic [W-1:0] result;
    logic         flag_error;
    sar_state_t   dbg_state;

    logic [W-1:0] hidden_a;
    logic         force_bad;
    int           n_vec    = 0;
    int           n_err    = 0;
    int           done_cnt = 0;
    int           exp_done = 0;

    sar_search_controller #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_greater  (a_greater),
        .equal      (equal),
        .b_greater  (b_greater),
        .probe      (probe),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flag_error (flag_error),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural comparator; force_bad drives the illegal all-zero pattern.
    always_comb begin
        if (force_bad) begin
            a_greater = 1'b0;
            equal     = 1'b0;
            b_greater = 1'b0;
        end else begin
            a_greater = (hidden_a > probe);
            equal     = (hidden_a == probe);
            b_greater = (hidden_a < probe);
        end
    end

    // Count done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one search starting at a negedge; ends at a negedge with DUT idle.
    // bad_step: compare step (0-based) on which flags are forced to 000, -1 none.
    // noise: hold start high through busy and DONE (must be ignored).
    task automatic run_search(input logic [W-1:0] a, input int bad_step,
                              input bit noise, input string tag);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] decided, trial, bit_mask;
        bit           err_exp;
        int           n_steps;
        // Reference: MSB-first binary search over the hidden value.
        decided = '0;
        err_exp = 1'b0;
        n_steps = 0;
        for (int i = 0; i < W; i++) begin
            bit_mask = W'(1) << (W - 1 - i);
            trial    = decided | bit_mask;
            exp_q.push_back(trial);
            n_steps++;
            if (i == bad_step) begin
                err_exp = 1'b1;
                decided = trial;
            end else begin
`ifdef SAR_EARLY_EXIT_EN
                if (a == trial) begin
                    decided = trial;
                    break;
                end
`endif
                decided = (a < trial) ? (trial & ~bit_mask) : trial;
            end
        end

        hidden_a = a;
        start    = 1'b1;
        @(negedge clk);
        start = noise;
        for (int s = 0; s < n_steps; s++) begin
            force_bad = (s == bad_step);
            chk($sformatf("%s_busy%0d", tag, s), 32'(busy), 32'd1);
            chk($sformatf("%s_probe%0d", tag, s), 32'(probe), 32'(exp_q[s]));
            chk($sformatf("%s_nodone%0d", tag, s), 32'(done), 32'd0);
            chk($sformatf("%s_ferr%0d", tag, s), 32'(flag_error),
                32'((bad_step >= 0) && (s > bad_step)));
            @(negedge clk);
        end
        force_bad = 1'b0;
        exp_done++;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(decided));
        chk({tag, "_ferr_done"}, 32'(flag_error), 32'(err_exp));
        if (bad_step < 0) chk({tag, "_result_eq_a"}, 32'(result), 32'(a));
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_held"}, 32'(result), 32'(decided));
        chk({tag, "_ferr_held"}, 32'(flag_error), 32'(err_exp));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        hidden_a  = '0;
        force_bad = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_probe", 32'(probe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ferr", 32'(flag_error), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Directed searches
        run_search(4'b1011, -1, 1'b0, "t1");
        run_search(4'b0000, -1, 1'b0, "t2_zero");
        run_search(4'b1111, -1, 1'b0, "t2_ones");
        run_search(4'b1000, -1, 1'b0, "t3_msb");

        // Reset during the second compare cycle
        hidden_a = 4'b0110;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t4_busy2", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_probe", 32'(probe), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_result", 32'(result), 32'd0);
        chk("t4_ferr", 32'(flag_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t4_quiet%0d", i), 32'(done | busy), 32'd0);
        end
        run_search(4'b0110, -1, 1'b0, "t4_after");

        // Illegal flags on step 2, then a clean run clears flag_error
        run_search(4'b1011, 1, 1'b0, "t5_bad");
        run_search(4'b0011, -1, 1'b0, "t5_clear");

        // start held during busy/DONE is ignored
        run_search(4'b0101, -1, 1'b1, "t6_noise");

        // Exhaustive sweep
        for (int v = 0; v < 16; v++) begin
            run_search(W'(v), -1, 1'($urandom_range(0, 1)), $sformatf("sweep%0d", v));
        end

        // Randomized runs with random gaps and occasional illegal flags
        for (int r = 0; r < 20; r++) begin
            int bad;
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_search(W'($urandom_range(0, 15)), bad, 1'($urandom_range(0, 1)),
                       $sformatf("rand%0d", r));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("gap_busy", 32'(busy), 32'd0);
            end
        end

        chk("done_count", 32'(done_cnt), 32'(exp_done));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
